serial_link_vc_credit_scheduler: RTL and testbench

// - Shares one serial-link send path between NumVc virtual channels (VCs), each with its own credit-based flow control.
// - Per VC: tracks credits available at the far side and credits owed back.
// - Round-robin arbitrates between data beats and credit-only beats; drives one registered beat per handshake.
// - Sits between the per-VC AXI-stream sources and the link framing/PHY layer.

---
 rtl/serial_link_vc_credit_scheduler_pkg.sv | 27 ++
 rtl/serial_link_vc_credit_scheduler_counter.sv | 65 ++++++
 rtl/serial_link_vc_credit_scheduler.sv | 126 ++++++++++++
 tb/tb_serial_link_vc_credit_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_vc_credit_scheduler_pkg.sv
// Shared types and width helpers for the serial-link VC credit scheduler.
// The beat types below describe the default configuration (2 VCs, 32-bit data, 8 credits).
package serial_link_pkg;

  localparam int NUM_VC      = 2;
  localparam int DATA_W      = 32;
  localparam int NUM_CREDITS = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int credit_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef logic [idx_width(NUM_VC)-1:0]          vc_id_t;
  typedef logic [credit_width(NUM_CREDITS)-1:0]  credit_t;

  typedef struct packed {
    logic              is_data;
    vc_id_t            vc;
    credit_t           credits;
    logic [DATA_W-1:0] data;
  } link_beat_t;

endpackage

// File: rtl/serial_link_vc_credit_scheduler_counter.sv
// Per-VC credit state: far-side credits available, credits owed back, eligibility.
// SERIAL_LINK_VC_STATS_EN adds a saturating 16-bit credit-stall cycle counter.
module serial_link_vc_credit_counter
  import serial_link_pkg::*;
#(
  parameter int NumCredits      = NUM_CREDITS,
  parameter int ForceSendThresh = NumCredits - 2,
  parameter int CreditWidth     = credit_width(NumCredits)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid,
  input  logic                   grant,
  input  logic                   data_load,
  input  logic [CreditWidth-1:0] rx_credits,
  input  logic                   consume,
  output logic [CreditWidth-1:0] owed,
  output logic                   data_elig,
  output logic                   credit_elig,
  output logic [15:0]            stall_cnt
);

  logic [CreditWidth-1:0] avail;
  logic [CreditWidth:0]   avail_sum;
  logic [CreditWidth:0]   owed_sum;

  // The last credit is held back until it can carry owed credits with it,
  // otherwise both ends could sit at zero credits with credits owed.
  assign data_elig   = valid && (avail != '0) &&
                       !((avail == CreditWidth'(1)) && (owed == '0));
  assign credit_elig = (owed >= CreditWidth'(ForceSendThresh)) && !data_elig;

  // A grant ships the whole snapshot; a same-cycle consume survives it.
  assign avail_sum = {1'b0, avail} + {1'b0, rx_credits} - (CreditWidth+1)'(data_load);
  assign owed_sum  = (grant ? '0 : {1'b0, owed}) + (CreditWidth+1)'(consume);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail <= CreditWidth'(NumCredits);
      owed  <= '0;
    end else begin
      avail <= avail_sum[CreditWidth-1:0];
      owed  <= owed_sum[CreditWidth-1:0];
    end
  end

`ifdef SERIAL_LINK_VC_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (valid && !data_elig && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  avail_range: assert property (@(posedge clk) disable iff (!rst_n)
    avail_sum <= (CreditWidth+1)'(NumCredits));
  owed_range: assert property (@(posedge clk) disable iff (!rst_n)
    owed_sum <= (CreditWidth+1)'(NumCredits));

endmodule

// File: rtl/serial_link_vc_credit_scheduler.sv
// Round-robin scheduler sharing one link send path between credit-flow-controlled VCs.
// SERIAL_LINK_VC_STATS_EN enables per-VC credit-stall counters on stall_cnt_o.
module serial_link_vc_credit_scheduler
  import serial_link_pkg::*;
#(
  parameter int NumVc           = NUM_VC,
  parameter int DataWidth       = DATA_W,
  parameter int NumCredits      = NUM_CREDITS,
  parameter int ForceSendThresh = NumCredits - 2,
  parameter int CreditWidth     = credit_width(NumCredits),
  parameter int VcIdWidth       = idx_width(NumVc)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumVc-1:0][DataWidth-1:0]  vc_data_i,
  input  logic [NumVc-1:0]                 vc_valid_i,
  output logic [NumVc-1:0]                 vc_ready_o,
  output logic [DataWidth-1:0]             link_data_o,
  output logic [VcIdWidth-1:0]             link_vc_o,
  output logic [CreditWidth-1:0]           link_credits_o,
  output logic                             link_is_data_o,
  output logic                             link_valid_o,
  input  logic                             link_ready_i,
  input  logic                             rx_valid_i,
  input  logic [VcIdWidth-1:0]             rx_vc_i,
  input  logic [CreditWidth-1:0]           rx_credits_i,
  input  logic [NumVc-1:0]                 rx_consumed_i,
  output logic [NumVc-1:0][15:0]           stall_cnt_o
);

  typedef struct packed {
    logic                   is_data;
    logic [VcIdWidth-1:0]   vc;
    logic [CreditWidth-1:0] credits;
    logic [DataWidth-1:0]   data;
  } beat_t;

  logic [NumVc-1:0][CreditWidth-1:0] owed;
  logic [NumVc-1:0][CreditWidth-1:0] rx_add;
  logic [NumVc-1:0]                  data_elig, credit_elig, elig;
  logic [NumVc-1:0]                  grant, data_load;
  logic [VcIdWidth-1:0]              win, rr_ptr;
  logic [VcIdWidth:0]                idx;
  logic                              any_elig, load, valid_q;
  beat_t                             beat_q;

  for (genvar v = 0; v < NumVc; v++) begin : g_vc
    assign rx_add[v] = (rx_valid_i && (rx_vc_i == VcIdWidth'(v))) ? rx_credits_i : '0;

    serial_link_vc_credit_counter #(
      .NumCredits      (NumCredits),
      .ForceSendThresh (ForceSendThresh),
      .CreditWidth     (CreditWidth)
    ) u_cnt (
      .clk         (clk_i),
      .rst_n       (rst_ni),
      .valid       (vc_valid_i[v]),
      .grant       (grant[v]),
      .data_load   (data_load[v]),
      .rx_credits  (rx_add[v]),
      .consume     (rx_consumed_i[v]),
      .owed        (owed[v]),
      .data_elig   (data_elig[v]),
      .credit_elig (credit_elig[v]),
      .stall_cnt   (stall_cnt_o[v])
    );
  end

  assign elig = data_elig | credit_elig;
  assign load = !valid_q || link_ready_i;

  // rr_ptr is the highest-priority VC; scan downward so the closest eligible wins.
  always_comb begin
    win      = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int i = NumVc - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (VcIdWidth+1)'(i);
      if (idx >= (VcIdWidth+1)'(NumVc)) idx = idx - (VcIdWidth+1)'(NumVc);
      if (elig[idx[VcIdWidth-1:0]]) begin
        win      = idx[VcIdWidth-1:0];
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (load && any_elig) grant[win] = 1'b1;
  end

  assign data_load  = grant & data_elig;
  assign vc_ready_o = data_load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
      rr_ptr  <= '0;
    end else if (load) begin
      valid_q <= any_elig;
      if (any_elig) begin
        beat_q.is_data <= data_elig[win];
        beat_q.vc      <= win;
        beat_q.credits <= owed[win];
        beat_q.data    <= data_elig[win] ? vc_data_i[win] : '0;
        rr_ptr         <= (win == VcIdWidth'(NumVc - 1)) ? '0 : win + 1'b1;
      end else begin
        beat_q <= '0;
      end
    end
  end

  assign link_valid_o   = valid_q;
  assign link_is_data_o = beat_q.is_data;
  assign link_vc_o      = beat_q.vc;
  assign link_credits_o = beat_q.credits;
  assign link_data_o    = beat_q.data;

  thresh_pos: assert property (@(posedge clk_i) ForceSendThresh > 0);
  ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(vc_ready_o));
  link_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (link_valid_o && !link_ready_i) |=> (link_valid_o && $stable(beat_q)));

endmodule

// File: tb/tb_serial_link_vc_credit_scheduler.sv
// Directed scoreboard bench for serial_link_vc_credit_scheduler (default 2 VC / 32b / 8 credits).
module tb_serial_link_vc_credit_scheduler;

  localparam int NumVc = 2;
  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int VW    = 1;

  typedef struct packed {
    logic          is_data;
    logic [VW-1:0] vc;
    logic [CW-1:0] credits;
    logic [DW-1:0] data;
  } beat_t;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [NumVc-1:0][DW-1:0] vc_data_i;
  logic [NumVc-1:0]         vc_valid_i = '0;
  logic [NumVc-1:0]         vc_ready_o;
  logic [DW-1:0]            link_data_o;
  logic [VW-1:0]            link_vc_o;
  logic [CW-1:0]            link_credits_o;
  logic                     link_is_data_o;
  logic                     link_valid_o;
  logic                     link_ready_i = 1'b1;
  logic                     rx_valid_i;
  logic [VW-1:0]            rx_vc_i;
  logic [CW-1:0]            rx_credits_i;
  logic [NumVc-1:0]         rx_consumed_i = '0;
  logic [NumVc-1:0][15:0]   stall_cnt_o;
  logic                     loop_en = 1'b0;

  beat_t exp_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    seq [NumVc];
  int    rdy_cnt [NumVc];
  int    exp_stall;

  serial_link_vc_credit_scheduler dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .vc_data_i      (vc_data_i),
    .vc_valid_i     (vc_valid_i),
    .vc_ready_o     (vc_ready_o),
    .link_data_o    (link_data_o),
    .link_vc_o      (link_vc_o),
    .link_credits_o (link_credits_o),
    .link_is_data_o (link_is_data_o),
    .link_valid_o   (link_valid_o),
    .link_ready_i   (link_ready_i),
    .rx_valid_i     (rx_valid_i),
    .rx_vc_i        (rx_vc_i),
    .rx_credits_i   (rx_credits_i),
    .rx_consumed_i  (rx_consumed_i),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Far side returns one credit for every data beat it accepts.
  assign rx_valid_i   = loop_en && link_valid_o && link_ready_i && link_is_data_o;
  assign rx_vc_i      = link_vc_o;
  assign rx_credits_i = CW'(1);

  // Source model: each VC presents {vc, sequence number}, advancing on accept.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) for (int v = 0; v < NumVc; v++) seq[v] <= 0;
    else for (int v = 0; v < NumVc; v++) if (vc_ready_o[v]) seq[v] <= seq[v] + 1;
  end

  always_comb
    for (int v = 0; v < NumVc; v++) vc_data_i[v] = {8'(v), 24'(seq[v])};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic beat_t dbeat(input int vc, input int n, input int cr);
    return {1'b1, VW'(vc), CW'(cr), 8'(vc), 24'(n)};
  endfunction

  function automatic beat_t cbeat(input int vc, input int cr);
    return {1'b0, VW'(vc), CW'(cr), 32'd0};
  endfunction

  // Monitor: scoreboard pop on handshake, stability check while held.
  beat_t got, prev;
  logic  prev_hold = 1'b0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_hold = 1'b0;
    end else begin
      got = {link_is_data_o, link_vc_o, link_credits_o, link_data_o};
      if (prev_hold) chk("hold_stable", {link_valid_o, got}, {1'b1, prev});
      if (link_valid_o && link_ready_i) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 64'(exp_q.size()), 64'd1);
        else chk("beat", got, exp_q.pop_front());
      end
      for (int v = 0; v < NumVc; v++) if (vc_ready_o[v]) rdy_cnt[v]++;
      prev_hold = link_valid_o && !link_ready_i;
      prev      = got;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    vc_valid_i    = '0;
    rx_consumed_i = '0;
    link_ready_i  = 1'b1;
    loop_en       = 1'b0;
    exp_q.delete();
    for (int v = 0; v < NumVc; v++) rdy_cnt[v] = 0;
    tick(2);
    rst_ni = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", 64'(link_valid_o), 64'd0);
    chk("rst_ready", 64'(vc_ready_o), 64'd0);
    chk("rst_beat", {link_is_data_o, link_vc_o, link_credits_o, link_data_o}, 64'd0);
    chk("rst_stall", 64'(stall_cnt_o), 64'd0);

    // VC0 alone: 7 beats, then held at the last credit
    vc_valid_i = 2'b01;
    for (int n = 0; n < 7; n++) exp_q.push_back(dbeat(0, n, 0));
    tick(10);
    vc_valid_i = '0;
    tick(3);
    chk("guard_q_empty", 64'(exp_q.size()), 64'd0);
    chk("guard_ready_cnt", 64'(rdy_cnt[0]), 64'd7);

    // One consume releases the last credit with one returned credit
    vc_valid_i    = 2'b01;
    rx_consumed_i = 2'b01;
    exp_q.push_back(dbeat(0, 7, 1));
    tick(1);
    rx_consumed_i = '0;
    tick(5);
    vc_valid_i = '0;
    tick(2);
    chk("release_q_empty", 64'(exp_q.size()), 64'd0);
    chk("release_ready_cnt", 64'(rdy_cnt[0]), 64'd8);

    // Both VCs with credit loopback: strict alternation
    do_reset();
    loop_en    = 1'b1;
    vc_valid_i = 2'b11;
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back(dbeat(0, n, 0));
      exp_q.push_back(dbeat(1, n, 0));
    end
    tick(8);
    vc_valid_i = '0;
    tick(3);
    loop_en = 1'b0;
    chk("alt_q_empty", 64'(exp_q.size()), 64'd0);
    chk("alt_ready0", 64'(rdy_cnt[0]), 64'd4);
    chk("alt_ready1", 64'(rdy_cnt[1]), 64'd4);

    // Six consumes on VC1 with no traffic: one forced credit-only beat
    do_reset();
    rx_consumed_i = 2'b10;
    exp_q.push_back(cbeat(1, 6));
    tick(6);
    rx_consumed_i = '0;
    tick(3);
    chk("cred_q_empty", 64'(exp_q.size()), 64'd0);
    chk("cred_no_ready", 64'(rdy_cnt[1]), 64'd0);
    vc_valid_i = 2'b10;
    for (int n = 0; n < 7; n++) exp_q.push_back(dbeat(1, n, 0));
    tick(10);
    vc_valid_i = '0;
    tick(3);
    chk("cred_avail_q_empty", 64'(exp_q.size()), 64'd0);

    // Back-pressure: beat frozen, consumes accumulate for the next beat
    do_reset();
    link_ready_i = 1'b0;
    vc_valid_i   = 2'b01;
    exp_q.push_back(dbeat(0, 0, 0));
    exp_q.push_back(dbeat(0, 1, 3));
    tick(1);
    rx_consumed_i = 2'b01;
    tick(3);
    rx_consumed_i = '0;
    tick(1);
    chk("hold_no_grant", 64'(rdy_cnt[0]), 64'd1);
    link_ready_i = 1'b1;
    tick(1);
    vc_valid_i = '0;
    tick(3);
    chk("hold_q_empty", 64'(exp_q.size()), 64'd0);
    chk("hold_ready_cnt", 64'(rdy_cnt[0]), 64'd2);

    // Stall statistics: 7 sends then 20 guard-stalled cycles on VC1
    do_reset();
    vc_valid_i = 2'b10;
    for (int n = 0; n < 7; n++) exp_q.push_back(dbeat(1, n, 0));
    tick(27);
    vc_valid_i = '0;
    tick(2);
`ifdef SERIAL_LINK_VC_STATS_EN
    exp_stall = 20;
`else
    exp_stall = 0;
`endif
    chk("stall_vc1", 64'(stall_cnt_o[1]), 64'(exp_stall));
    chk("stall_vc0", 64'(stall_cnt_o[0]), 64'd0);
    chk("stall_q_empty", 64'(exp_q.size()), 64'd0);

    // Async reset while a beat is held drops it
    do_reset();
    link_ready_i = 1'b0;
    vc_valid_i   = 2'b01;
    tick(2);
    chk("midbeat_loaded", 64'(link_valid_o), 64'd1);
    rst_ni = 1'b0;
    #2;
    chk("midbeat_dropped", 64'(link_valid_o), 64'd0);
    do_reset();
    chk("midbeat_credits", 64'(link_credits_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
